// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue stage sitting in front of a 4-bit combinational ALU.  Commands are
//   buffered in a small FIFO, operands are fetched from a 4x4-bit register
//   file (or taken from an immediate), and the ALU result is written back
//   and offered on a valid/ready result stream.
//
// Ports
//   clk, rst          clock and asynchronous active-high reset
//   cmd_*_i / _o      command stream into the FIFO (cmd_ready_o == !full)
//   alu_a_o, alu_b_o  registered operands to the ALU
//   alu_opcode_o      registered opcode to the ALU (passed through opaquely)
//   alu_result_i      ALU result
//   alu_flags_i       ALU flags {carry, zero, negative, overflow}
//   res_*_o / _i      result stream: data, flags, destination register
//   dz_sticky_o       latched divide-by-zero indication, cleared by rst only
//   rd_addr_i         debug read index
//   rd_data_o         combinational debug read of the register file
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [3:0] cmd_opcode_i,
    input  logic [1:0] cmd_dst_i,
    input  logic [1:0] cmd_src_a_i,
    input  logic [1:0] cmd_src_b_i,
    input  logic       cmd_imm_en_i,
    input  logic [3:0] cmd_imm_i,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    output logic [3:0] alu_opcode_o,
    input  logic [3:0] alu_result_i,
    input  logic [3:0] alu_flags_i,
    output logic       res_valid_o,
    input  logic       res_ready_i,
    output logic [3:0] res_data_o,
    output logic [3:0] res_flags_o,
    output logic [1:0] res_dst_o,
    output logic       dz_sticky_o,
    input  logic [1:0] rd_addr_i,
    output logic [3:0] rd_data_o
);

    localparam logic [FIFO_AW:0] FullCount = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]       OpDiv     = 4'b0110;

    typedef struct packed {
        logic [3:0] opcode;
        logic [1:0] dst;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic       imm_en;
        logic [3:0] imm;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    cmd_t               fifo_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic [FIFO_AW:0]   count_d;

    state_t     state_q;
    logic [3:0] regs_q [4];
    logic [3:0] alu_a_q;
    logic [3:0] alu_b_q;
    logic [3:0] alu_opcode_q;
    logic [1:0] exec_dst_q;
    logic       res_valid_q;
    logic [3:0] res_data_q;
    logic [3:0] res_flags_q;
    logic [1:0] res_dst_q;
    logic       dz_sticky_q;

    logic       push;
    logic       pop;
    cmd_t       cmd_in;
    cmd_t       head;
    logic [3:0] alu_a_d;
    logic [3:0] alu_b_d;

    assign cmd_ready_o = (count_q != FullCount);
    assign push        = cmd_valid_i && cmd_ready_o;
    // Popping is tied to the FSM sitting in IDLE; there is no bypass path,
    // so a freshly pushed entry is only visible from the following cycle.
    assign pop         = (state_q == IDLE) && (count_q != '0);

    assign cmd_in = '{opcode: cmd_opcode_i, dst: cmd_dst_i, src_a: cmd_src_a_i,
                      src_b: cmd_src_b_i, imm_en: cmd_imm_en_i, imm: cmd_imm_i};
    assign head   = fifo_q[rd_ptr_q];

    // Operand fetch for the head entry; sampled into the ALU registers on pop.
    assign alu_a_d = regs_q[head.src_a];
    assign alu_b_d = head.imm_en ? head.imm : regs_q[head.src_b];

    // Occupancy tracking: a simultaneous push and pop leaves the count alone.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage needs no reset; only entries below count_q are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_in;
        end
    end

    // FIFO pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Issue FSM.  IDLE reads operands from the register file, EXEC writes the
    // settled ALU result back, RESP holds the result until it is consumed.
    // Writeback in EXEC always lands before the next IDLE read, so dependent
    // back-to-back commands see the updated register value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_opcode_q <= '0;
            exec_dst_q   <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_flags_q  <= '0;
            res_dst_q    <= '0;
            dz_sticky_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        alu_a_q      <= alu_a_d;
                        alu_b_q      <= alu_b_d;
                        alu_opcode_q <= head.opcode;
                        exec_dst_q   <= head.dst;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    regs_q[exec_dst_q] <= alu_result_i;
                    res_data_q         <= alu_result_i;
                    res_flags_q        <= alu_flags_i;
                    res_dst_q          <= exec_dst_q;
                    res_valid_q        <= 1'b1;
                    if ((alu_opcode_q == OpDiv) && (alu_b_q == 4'd0)) begin
                        dz_sticky_q <= 1'b1;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    if (res_valid_q && res_ready_i) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_opcode_o = alu_opcode_q;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign res_flags_o  = res_flags_q;
    assign res_dst_o    = res_dst_q;
    assign dz_sticky_o  = dz_sticky_q;
    assign rd_data_o    = regs_q[rd_addr_i];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Bench for alu_issue_ctrl.  A small behavioural ALU drives the DUT's ALU
//   inputs; a transaction-level reference model (command queue, register
//   array, per-command progress) predicts every DUT output each cycle.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int Depth = 4;
    localparam int MIdle = 0;
    localparam int MExec = 1;
    localparam int MResp = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_opcode;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic       cmd_imm_en;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_opcode;
    logic [3:0] alu_result;
    logic [3:0] alu_flags;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic [3:0] res_flags;
    logic [1:0] res_dst;
    logic       dz_sticky;
    logic [1:0] rd_addr;
    logic [3:0] rd_data;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_opcode_i (cmd_opcode),
        .cmd_dst_i    (cmd_dst),
        .cmd_src_a_i  (cmd_src_a),
        .cmd_src_b_i  (cmd_src_b),
        .cmd_imm_en_i (cmd_imm_en),
        .cmd_imm_i    (cmd_imm),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_opcode_o (alu_opcode),
        .alu_result_i (alu_result),
        .alu_flags_i  (alu_flags),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_data_o   (res_data),
        .res_flags_o  (res_flags),
        .res_dst_o    (res_dst),
        .dz_sticky_o  (dz_sticky),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data)
    );

    // Behavioural ALU: returns {carry, zero, negative, overflow, result}.
    function automatic logic [7:0] aluFn(input logic [3:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic       c;
        logic       v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd6: begin
                if (b == 4'd0) begin
                    r = 4'd0;
                    c = 1'b1;
                end else begin
                    r = a / b;
                end
            end
            4'd14:   r = 4'd0;
            default: r = ~a ^ b;
        endcase
        return {c, (r == 4'd0), r[3], v, r};
    endfunction

    assign {alu_flags, alu_result} = aluFn(alu_opcode, alu_a, alu_b);

    typedef struct {
        logic [3:0] op;
        logic [1:0] dst;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       ie;
        logic [3:0] imm;
    } mcmd_t;

    // Reference model state
    mcmd_t      mQ[$];
    logic [3:0] mRegs [4];
    int         mPhase;
    logic [3:0] mA, mB, mOp, mResData, mResFlags;
    logic [1:0] mDst, mResDst;
    logic       mResValid, mDz;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] gotData[$];
    logic [3:0] gotFlags[$];

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        for (int i = 0; i < 4; i++) mRegs[i] = 4'd0;
        mPhase    = MIdle;
        mA        = 4'd0;
        mB        = 4'd0;
        mOp       = 4'd0;
        mDst      = 2'd0;
        mResData  = 4'd0;
        mResFlags = 4'd0;
        mResDst   = 2'd0;
        mResValid = 1'b0;
        mDz       = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        logic [7:0] fr;
        mcmd_t      c;
        bit         acceptNow;
        acceptNow = cmd_valid && (mQ.size() < Depth);
        case (mPhase)
            MIdle: begin
                if (mQ.size() > 0) begin
                    c      = mQ.pop_front();
                    mA     = mRegs[c.sa];
                    mB     = c.ie ? c.imm : mRegs[c.sb];
                    mOp    = c.op;
                    mDst   = c.dst;
                    mPhase = MExec;
                end
            end
            MExec: begin
                fr          = aluFn(mOp, mA, mB);
                mRegs[mDst] = fr[3:0];
                mResData    = fr[3:0];
                mResFlags   = fr[7:4];
                mResDst     = mDst;
                mResValid   = 1'b1;
                if (mOp == 4'b0110 && mB == 4'd0) mDz = 1'b1;
                mPhase = MResp;
            end
            default: begin
                if (res_ready) begin
                    mResValid = 1'b0;
                    mPhase    = MIdle;
                end
            end
        endcase
        if (acceptNow) begin
            c.op  = cmd_opcode;
            c.dst = cmd_dst;
            c.sa  = cmd_src_a;
            c.sb  = cmd_src_b;
            c.ie  = cmd_imm_en;
            c.imm = cmd_imm;
            mQ.push_back(c);
        end
    endtask

    task automatic checkOutput();
        checkVal("cmd_ready", 8'(cmd_ready), 8'(mQ.size() < Depth));
        checkVal("alu_a", 8'(alu_a), 8'(mA));
        checkVal("alu_b", 8'(alu_b), 8'(mB));
        checkVal("alu_opcode", 8'(alu_opcode), 8'(mOp));
        checkVal("res_valid", 8'(res_valid), 8'(mResValid));
        checkVal("res_data", 8'(res_data), 8'(mResData));
        checkVal("res_flags", 8'(res_flags), 8'(mResFlags));
        checkVal("res_dst", 8'(res_dst), 8'(mResDst));
        checkVal("dz_sticky", 8'(dz_sticky), 8'(mDz));
        checkVal("rd_data", 8'(rd_data), 8'(mRegs[rd_addr]));
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [1:0] dst,
                                 input logic [1:0] sa, input logic [1:0] sb, input logic ie,
                                 input logic [3:0] imm, input logic rdy);
        cmd_valid  = v;
        cmd_opcode = op;
        cmd_dst    = dst;
        cmd_src_a  = sa;
        cmd_src_b  = sb;
        cmd_imm_en = ie;
        cmd_imm    = imm;
        res_ready  = rdy;
    endtask

    // One cycle: compare at negedge+1, log handshakes, step model, next negedge.
    task automatic tick();
        rd_addr = 2'($urandom_range(0, 3));
        #1;
        checkOutput();
        if (res_valid === 1'b1 && res_ready) begin
            gotData.push_back(res_data);
            gotFlags.push_back(res_flags);
        end
        modelStep();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pushOne(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                           input logic [1:0] sb, input logic ie, input logic [3:0] imm);
        bit acc;
        bit done;
        done = 1'b0;
        applyStimulus(1'b1, op, dst, sa, sb, ie, imm, res_ready);
        for (int i = 0; i < 40 && !done; i++) begin
            acc = (mQ.size() < Depth);
            tick();
            if (acc) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: got no accept expected accept within 40 cycles");
        end
        cmd_valid = 1'b0;
    endtask

    task automatic applyReset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput();
        checkVal("rst_res_valid", 8'(res_valid), 8'd0);
        checkVal("rst_cmd_ready", 8'(cmd_ready), 8'd1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            checkVal("rst_reg", 8'(rd_data), 8'd0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        rd_addr = 2'd0;
        applyStimulus(1'b0, 4'd0, 2'd0, 2'd0, 2'd0, 1'b0, 4'd0, 1'b1);
        modelReset();
        @(negedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Dependent adds: r1 = r0 + 5, r2 = r1 + 3
        res_ready = 1'b1;
        pushOne(4'd0, 2'd1, 2'd0, 2'd0, 1'b1, 4'd5);
        pushOne(4'd0, 2'd2, 2'd1, 2'd0, 1'b1, 4'd3);
        idle(8);
        checkVal("t1_count", 8'(gotData.size()), 8'd2);
        checkVal("t1_res0", 8'(gotData[0]), 8'd5);
        checkVal("t1_res1", 8'(gotData[1]), 8'd8);
        checkVal("t1_zero0", 8'(gotFlags[0][2]), 8'd0);
        checkVal("t1_zero1", 8'(gotFlags[1][2]), 8'd0);
        checkVal("t1_model_r2", 8'(mRegs[2]), 8'd8);
        rd_addr = 2'd2;
        #1;
        checkVal("t1_rd_r2", 8'(rd_data), 8'd8);
        gotData.delete();
        gotFlags.delete();

        // Wrap-around add: r0 = 0+1, then r0 = 1+F -> 0 with carry and zero
        pushOne(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'd1);
        pushOne(4'd0, 2'd0, 2'd0, 2'd0, 1'b1, 4'hF);
        idle(8);
        checkVal("t2_count", 8'(gotData.size()), 8'd2);
        checkVal("t2_res1", 8'(gotData[1]), 8'd0);
        checkVal("t2_flags1", 8'(gotFlags[1]), 8'hC);
        gotData.delete();
        gotFlags.delete();

        // Divide by zero immediate, then an ordinary add
        pushOne(4'b0110, 2'd3, 2'd1, 2'd0, 1'b1, 4'd0);
        idle(6);
        checkVal("t3_res", 8'(gotData[0]), 8'd0);
        checkVal("t3_carry", 8'(gotFlags[0][3]), 8'd1);
        checkVal("t3_dz", 8'(dz_sticky), 8'd1);
        pushOne(4'd0, 2'd3, 2'd2, 2'd0, 1'b1, 4'd1);
        idle(6);
        checkVal("t3_dz_held", 8'(dz_sticky), 8'd1);
        gotData.delete();
        gotFlags.delete();

        // Back-pressure: five accepted, sixth held off until results drain
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pushOne(4'(i), 2'(i), 2'(i + 1), 2'(i + 2), 1'(i % 2), 4'(3 * i + 1));
        end
        applyStimulus(1'b1, 4'd1, 2'd0, 2'd1, 2'd2, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        checkVal("t4_full_model", 8'(mQ.size()), 8'd4);
        checkVal("t4_full_ready", 8'(cmd_ready), 8'd0);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        idle(25);
        checkVal("t4_delivered", 8'(gotData.size()), 8'd5);
        gotData.delete();
        gotFlags.delete();

        // Reset during EXEC with two commands still queued
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pushOne(4'd0, 2'(i), 2'(i), 2'd0, 1'b1, 4'(i + 7));
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        checkVal("t5_pre_phase", 8'(mPhase), 8'(MExec));
        checkVal("t5_pre_queued", 8'(mQ.size()), 8'd2);
        applyReset();
        res_ready = 1'b1;
        idle(6);

        // Hold occupancy at three while pushing exactly on pop cycles
        for (int i = 0; i < 30 && mQ.size() != 3; i++) begin
            applyStimulus(1'b1, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1,
                          4'($urandom_range(0, 15)), 1'b1);
            tick();
        end
        checkVal("t6_fill", 8'(mQ.size()), 8'd3);
        for (int i = 0; i < 15; i++) begin
            applyStimulus((mPhase == MIdle) && (mQ.size() > 0), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), 1'b1);
            tick();
            checkVal("t6_count", 8'(mQ.size()), 8'd3);
            checkVal("t6_ready", 8'(cmd_ready), 8'd1);
        end
        idle(15);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            tick();
        end
        res_ready = 1'b1;
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
